// File: rtl/btn_press_conditioner.sv
// ============================================================================
//  Module      : btn_press_conditioner
//  Description : Synchronises and debounces a raw push-button, emitting
//                PRESS / RELEASE / LONG_PRESS / REPEAT pulses and a clean level.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic BTN_RST,
    input  logic BTN_IN,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS,
    output logic REPEAT,
    output logic LEVEL
);

    localparam logic [CNT_W-1:0] C_DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_HELD       = 3'd2,
        S_LONG_HELD  = 3'd3,
        S_DB_RELEASE = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long;
    logic             r_s1;
    logic             r_s2;
    logic             r_press;
    logic             r_release;
    logic             r_long_press;
    logic             r_repeat;
    logic             r_level;

    always_ff @(posedge CLK) begin
        if (BTN_RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_long       <= 1'b0;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;
            r_level      <= 1'b0;
        end else begin
            r_s1         <= BTN_IN;
            r_s2         <= r_s1;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_s2) begin
                        r_state <= S_DB_PRESS;
                        r_cnt   <= C_ONE;
                    end
                end

                S_DB_PRESS: begin
                    if (!r_s2) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                        r_long  <= 1'b0;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                S_HELD: begin
                    if (!r_s2) begin
                        r_state <= S_DB_RELEASE;
                        r_cnt   <= C_ONE;
                    end else if (r_cnt == C_LONG_LAST) begin
                        r_state      <= S_LONG_HELD;
                        r_cnt        <= '0;
                        r_long_press <= 1'b1;
                        r_long       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                S_LONG_HELD: begin
                    if (!r_s2) begin
                        r_state <= S_DB_RELEASE;
                        r_cnt   <= C_ONE;
                    end else if (r_cnt == C_REPEAT_LAST) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                S_DB_RELEASE: begin
                    // A bounce back to pressed resumes the hold with a fresh period
                    if (r_s2) begin
                        r_state <= r_long ? S_LONG_HELD : S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign PRESS      = r_press;
    assign RELEASE    = r_release;
    assign LONG_PRESS = r_long_press;
    assign REPEAT     = r_repeat;
    assign LEVEL      = r_level;

endmodule

`default_nettype wire
